// File: rtl/i2c_reg_bridge_pkg.sv
// Shared types for the I2C register bridge: FSM states and byte-index type.
package i2c_reg_bridge_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        READ_S  = 2'd0,
        READY_S = 2'd1,
        WRITE_S = 2'd2
    } StateType;

    // Selects one of up to four address/data bytes.
    typedef logic [1:0] IdxType;

endpackage

// File: rtl/i2c_reg_bridge.sv
// Bridges I2C slave byte streams to an auto-incrementing register bus; rxAck one cycle after consume, regWr from the same edge.
// No byte is consumed outside READY_S, so the slave stretches SCL while a register access is pending.
module i2c_reg_bridge
    import i2c_reg_bridge_pkg::*;
#(
    parameter int TPD_P        = 1,
    parameter int ADDR_BYTES_P = 1,
    parameter int DATA_BYTES_P = 1,
    parameter bit ENDIAN_P     = 1'b1,
    parameter int TIMEOUT_P    = 255
) (
    input  logic                      clk,
    input  logic                      aRstN,
    output logic                      enable,
    input  logic                      rxActive,
    input  logic                      rxValid,
    input  logic [BYTE_W-1:0]         rxData,
    output logic                      rxAck,
    input  logic                      txActive,
    input  logic                      txAck,
    input  logic                      nack,
    output logic                      txValid,
    output logic [BYTE_W-1:0]         txData,
    output logic [8*ADDR_BYTES_P-1:0] regAddr,
    output logic                      regWr,
    output logic [8*DATA_BYTES_P-1:0] regWrData,
    output logic                      regRd,
    input  logic [8*DATA_BYTES_P-1:0] regRdData,
    input  logic                      regAck,
    output logic                      regTimeout
);

    localparam int AW = 8 * ADDR_BYTES_P;
    localparam int DW = 8 * DATA_BYTES_P;
    localparam int TW = $clog2(TIMEOUT_P + 1);
    localparam IdxType ADDR_LAST = IdxType'(ADDR_BYTES_P - 1);
    localparam IdxType DATA_LAST = IdxType'(DATA_BYTES_P - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_P - 1);

    typedef struct packed {
        StateType      state;
        logic          enable;
        logic          rx_active;
        logic          start_pend;
        logic          addr_phase;
        IdxType        addr_idx;
        IdxType        byte_idx;
        IdxType        data_idx;
        logic [AW-1:0] ptr;
        logic [DW-1:0] rd_buf;
        logic [DW-1:0] wr_buf;
        logic          rx_ack;
        logic          reg_rd;
        logic          reg_wr;
        logic          timeout;
        logic [TW-1:0] tmo_cnt;
    } RegType;

    localparam RegType REG_INIT = '{state: READ_S, default: '0};

    RegType r_q, r_d;

    // Wire position of the idx-th transferred byte within a data word.
    function automatic IdxType lane(input IdxType idx);
        return ENDIAN_P ? IdxType'(DATA_LAST - idx) : idx;
    endfunction

    function automatic logic [7:0] get_byte(input logic [DW-1:0] buf_v, input IdxType idx);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < DATA_BYTES_P; i++)
            if (idx == IdxType'(i)) b = buf_v[8*i +: 8];
        return b;
    endfunction

    function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] buf_v, input IdxType idx,
                                               input logic [7:0] b);
        logic [DW-1:0] res;
        res = buf_v;
        for (int i = 0; i < DATA_BYTES_P; i++)
            if (idx == IdxType'(i)) res[8*i +: 8] = b;
        return res;
    endfunction

    always_comb begin
        r_d           = r_q;
        r_d.enable    = 1'b1;
        r_d.rx_ack    = 1'b0;
        r_d.timeout   = 1'b0;
        r_d.rx_active = rxActive;

        // A start seen mid-access is held until the FSM is back in READY_S.
        if (rxActive && !r_q.rx_active) r_d.start_pend = 1'b1;
        if (!rxActive && r_q.rx_active) begin
            r_d.start_pend = 1'b0;
            r_d.addr_phase = 1'b0;
            r_d.data_idx   = '0;
        end

        unique case (r_q.state)
            READ_S: begin
                if (!r_q.reg_rd) begin
                    r_d.reg_rd  = 1'b1;
                    r_d.tmo_cnt = '0;
                end else if (regAck) begin
                    r_d.reg_rd   = 1'b0;
                    r_d.rd_buf   = regRdData;
                    r_d.byte_idx = '0;
                    r_d.state    = READY_S;
                end else if (r_q.tmo_cnt == TMO_LAST) begin
                    r_d.reg_rd   = 1'b0;
                    r_d.rd_buf   = '1;
                    r_d.byte_idx = '0;
                    r_d.timeout  = 1'b1;
                    r_d.state    = READY_S;
                end else begin
                    r_d.tmo_cnt = r_q.tmo_cnt + 1'b1;
                end
            end
            READY_S: begin
                if (r_d.start_pend) begin
                    r_d.start_pend = 1'b0;
                    r_d.addr_phase = 1'b1;
                    r_d.addr_idx   = '0;
                    r_d.data_idx   = '0;
                end
                if (rxValid && !r_q.rx_ack) begin
                    r_d.rx_ack = 1'b1;
                    if (r_d.addr_phase) begin
                        r_d.ptr = AW'({r_q.ptr, rxData});
                        if (r_d.addr_idx == ADDR_LAST) begin
                            r_d.addr_phase = 1'b0;
                            r_d.addr_idx   = '0;
                            r_d.state      = READ_S;
                        end else begin
                            r_d.addr_idx = r_d.addr_idx + 1'b1;
                        end
                    end else begin
                        r_d.wr_buf = put_byte(r_q.wr_buf, lane(r_d.data_idx), rxData);
                        if (r_d.data_idx == DATA_LAST) begin
                            r_d.data_idx = '0;
                            r_d.reg_wr   = 1'b1;
                            r_d.tmo_cnt  = '0;
                            r_d.state    = WRITE_S;
                        end else begin
                            r_d.data_idx = r_d.data_idx + 1'b1;
                        end
                    end
                end else if (txAck) begin
                    if (r_q.byte_idx == DATA_LAST) begin
                        r_d.ptr   = r_q.ptr + 1'b1;
                        r_d.state = READ_S;
                    end else begin
                        r_d.byte_idx = r_q.byte_idx + 1'b1;
                    end
                end
            end
            WRITE_S: begin
                if (regAck || r_q.tmo_cnt == TMO_LAST) begin
                    r_d.reg_wr  = 1'b0;
                    r_d.timeout = !regAck;
                    r_d.ptr     = r_q.ptr + 1'b1;
                    r_d.state   = READ_S;
                end else begin
                    r_d.tmo_cnt = r_q.tmo_cnt + 1'b1;
                end
            end
            default: r_d.state = READ_S;
        endcase
    end

    always_ff @(posedge clk or negedge aRstN) begin
        if (!aRstN) r_q <= REG_INIT;
        else        r_q <= r_d;
    end

    assign enable     = r_q.enable;
    assign rxAck      = r_q.rx_ack;
    assign txValid    = (r_q.state == READY_S);
    assign txData     = get_byte(r_q.rd_buf, lane(r_q.byte_idx));
    assign regAddr    = r_q.ptr;
    assign regWr      = r_q.reg_wr;
    assign regWrData  = r_q.wr_buf;
    assign regRd      = r_q.reg_rd;
    assign regTimeout = r_q.timeout;

    // Observation-only and reserved inputs; the delay parameter has no synthesizable meaning.
    logic unused_ok;
    assign unused_ok = ^{txActive, nack, (TPD_P != 0)};

endmodule
